pulse_event_arbiter: RTL and testbench

- Turns N level-type request lines into one-shot rising-edge events and queues one pending bit per line.
- Issues pending events one at a time, round-robin, over a valid/ready handshake to a single shared consumer (command issuer / interrupt sink).
- Enforces a programmable idle gap between issues.
- Sits between front-panel/peripheral level signals and the CPU-side event port.

---
 rtl/pulse_event_arbiter_pkg.sv | 34 +++
 rtl/pulse_event_arbiter_if.sv | 32 +++
 rtl/pulse_rise_detect.sv | 61 ++++++
 rtl/pulse_event_arbiter.sv | 171 +++++++++++++++++
 tb/tb_pulse_event_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_event_arbiter_pkg
// Purpose  : Shared definitions for the pulse event arbiter: FSM state
//            encoding and a ceil(log2) helper used to size the event index.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_event_arbiter_pkg;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = c_ST_IDLE,
    ISSUE = c_ST_ISSUE,
    GAP   = c_ST_GAP
  } arb_state_e;

  // Smallest w such that 2**w >= value (value >= 1).
  function automatic int clog2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_event_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_event_arbiter_if
// Purpose  : Valid/ready event port between the arbiter and its consumer.
// Signals  : out_valid - event offered
//            out_id    - index of the offered event, stable while valid
//            out_ready - consumer accepts on out_valid & out_ready
// Modports : master (arbiter side), slave (consumer side)
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_event_arbiter_if #(
  parameter int ID_W = 2
);

  logic            out_valid;
  logic [ID_W-1:0] out_id;
  logic            out_ready;

  modport master (
    output out_valid,
    output out_id,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_id,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/pulse_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : pulse_rise_detect
// Purpose  : One requester line: rising-edge detector, pending event bit and
//            sticky overflow bit.
// Ports    : clk, rst       - clock, async active-high reset
//            i_level        - level request (synchronous to clk)
//            i_select       - arbiter takes this line's pending event now
//            i_ovf_clear    - clears the overflow bit
//            o_pending      - an event is queued on this line
//            o_overflow     - an event was dropped since the last clear
// Revision : 1.0 - initial release
// ============================================================================
module pulse_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  input  logic i_select,
  input  logic i_ovf_clear,
  output logic o_pending,
  output logic o_overflow
);

  logic r_prev;
  logic r_pending;
  logic r_overflow;
  logic w_rise;

  // r_prev resets to 0, so a line held high across reset release yields
  // exactly one event.
  assign w_rise = i_level & ~r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev     <= 1'b0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_prev <= i_level;

      // A new edge arriving in the same cycle the old one is taken is kept.
      if (w_rise) begin
        r_pending <= 1'b1;
      end else if (i_select) begin
        r_pending <= 1'b0;
      end

      // Set has priority over clear so a drop is never silently lost.
      if (w_rise && r_pending && !i_select) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/pulse_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_event_arbiter
// Purpose  : Converts N level request lines into one-shot events, queues one
//            pending bit per line and issues them round-robin over a
//            valid/ready port, with a programmable idle gap after each issue.
// Ports    : clk, rst   - clock, async active-high reset
//            req_level  - level requests, synchronous to clk
//            evt        - event port (out_valid / out_id / out_ready)
//            pending    - queued, not yet selected events
//            overflow   - sticky per-line dropped-event flags
//            ovf_clear  - per-bit clear of overflow
//            busy       - FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module pulse_event_arbiter
  import pulse_event_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int GAP_CYCLES = 2,
  parameter int GAP_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_level,
  pulse_event_arbiter_if.master evt,
  output logic [N_REQ-1:0]     pending,
  output logic [N_REQ-1:0]     overflow,
  input  logic [N_REQ-1:0]     ovf_clear,
  output logic                 busy
);

  // Value loaded into the gap counter on a handshake; counter then runs
  // down to 0 giving GAP_CYCLES cycles in GAP.
  localparam logic [GAP_W-1:0] c_GAP_LOAD =
    GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  arb_state_e       r_state;
  arb_state_e       w_state_nx;
  logic             r_valid;
  logic             w_valid_nx;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  w_id_nx;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  w_rr_nx;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_nx;

  logic             w_found;
  logic [ID_W-1:0]  w_sel;
  logic             w_sel_en;
  logic [N_REQ-1:0] w_sel_onehot;

  // --------------------------------------------------------------------------
  // Per-line edge detect and pending/overflow storage
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_line
    pulse_rise_detect u_det (
      .clk        (clk),
      .rst        (rst),
      .i_level    (req_level[gi]),
      .i_select   (w_sel_onehot[gi]),
      .i_ovf_clear(ovf_clear[gi]),
      .o_pending  (pending[gi]),
      .o_overflow (overflow[gi])
    );
  end

  // --------------------------------------------------------------------------
  // Round-robin search: first pending line at or above r_rr_ptr, otherwise
  // the first pending line from 0 (wrap-around).
  // --------------------------------------------------------------------------
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_found && pending[j] && (j >= int'(r_rr_ptr))) begin
        w_found = 1'b1;
        w_sel   = ID_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_found && pending[j]) begin
        w_found = 1'b1;
        w_sel   = ID_W'(j);
      end
    end
  end

  always_comb begin
    w_sel_onehot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_sel_en && (w_sel == ID_W'(j))) begin
        w_sel_onehot[j] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and registered outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_valid_nx = r_valid;
    w_id_nx    = r_id;
    w_rr_nx    = r_rr_ptr;
    w_gap_nx   = r_gap;
    w_sel_en   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_sel_en   = 1'b1;
          w_id_nx    = w_sel;
          w_valid_nx = 1'b1;
          w_rr_nx    = (w_sel == ID_W'(N_REQ - 1)) ? '0 : (w_sel + ID_W'(1));
          w_state_nx = ISSUE;
        end
      end

      ISSUE: begin
        // out_valid is always 1 here; hold id until the consumer accepts.
        if (evt.out_ready) begin
          w_valid_nx = 1'b0;
          if (GAP_CYCLES > 0) begin
            w_gap_nx   = c_GAP_LOAD;
            w_state_nx = GAP;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end

      GAP: begin
        if (r_gap == '0) begin
          w_state_nx = IDLE;
        end else begin
          w_gap_nx = r_gap - GAP_W'(1);
        end
      end

      default: begin
        w_state_nx = IDLE;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_rr_ptr <= '0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_valid  <= w_valid_nx;
      r_id     <= w_id_nx;
      r_rr_ptr <= w_rr_nx;
      r_gap    <= w_gap_nx;
    end
  end

  assign evt.out_valid = r_valid;
  assign evt.out_id    = r_id;
  assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pulse_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_event_arbiter
// Purpose  : Directed self-checking bench. Stimulus pushes expected event ids
//            into per-DUT queues; negedge monitors pop and compare on every
//            handshake. One DUT uses GAP_CYCLES=2, a second GAP_CYCLES=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_event_arbiter;
  import pulse_event_arbiter_pkg::*;

  localparam int N_REQ = 4;
  localparam int ID_W  = clog2(N_REQ);
  localparam int GAP_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0] req, pend, ovf, ovf_clr;
  logic             busy;
  logic [N_REQ-1:0] req0, pend0, ovf0, ovf_clr0;
  logic             busy0;

  pulse_event_arbiter_if #(.ID_W(ID_W)) evt  ();
  pulse_event_arbiter_if #(.ID_W(ID_W)) evt0 ();

  pulse_event_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .GAP_CYCLES(2), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .req_level(req), .evt(evt),
    .pending(pend), .overflow(ovf), .ovf_clear(ovf_clr), .busy(busy)
  );

  pulse_event_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .GAP_CYCLES(0), .GAP_W(GAP_W)) dut0 (
    .clk(clk), .rst(rst), .req_level(req0), .evt(evt0),
    .pending(pend0), .overflow(ovf0), .ovf_clear(ovf_clr0), .busy(busy0)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int exp0_q[$];
  int cyc = 0;
  int last0 = 0;
  bit have_last0 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req_v);
    n_cmp++;
    if (act != req_v) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (evt.out_valid && evt.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut_unexpected_issue: actual id %0d required none", evt.out_id);
      end else begin
        chk("dut_issue_id", int'(evt.out_id), exp_q.pop_front());
      end
    end
    if (evt0.out_valid && evt0.out_ready) begin
      if (exp0_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut0_unexpected_issue: actual id %0d required none", evt0.out_id);
      end else begin
        chk("dut0_issue_id", int'(evt0.out_id), exp0_q.pop_front());
      end
      if (have_last0) chk("dut0_issue_spacing", cyc - last0, 2);
      last0      = cyc;
      have_last0 = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(exp_q.size() == 0 && !busy && pend == '0)) begin
      step(1);
      k++;
    end
    chk(name, int'(k < budget), 1);
  endtask

  task automatic wait_drain0(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(exp0_q.size() == 0 && !busy0 && pend0 == '0)) begin
      step(1);
      k++;
    end
    chk(name, int'(k < budget), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_REQ-1:0] nx;
    req = '0; ovf_clr = '0; req0 = '0; ovf_clr0 = '0;
    evt.out_ready = 1'b0; evt0.out_ready = 1'b0;
    rst = 1'b1;
    step(2);

    // Reset state
    chk("rst_valid",   int'(evt.out_valid), 0);
    chk("rst_id",      int'(evt.out_id), 0);
    chk("rst_pending", int'(pend), 0);
    chk("rst_overflow", int'(ovf), 0);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_busy0",   int'(busy0), 0);
    rst = 1'b0;
    step(4);
    chk("idle_busy", int'(busy), 0);

    // Single event on line 2, ready high before valid (must be ignored)
    req[2] = 1'b1;
    evt.out_ready = 1'b1;
    exp_q.push_back(2);
    step(1);
    chk("p1_pending_t1", int'(pend), 4'b0100);
    chk("p1_valid_t1",   int'(evt.out_valid), 0);
    step(1);
    chk("p1_valid_t2",   int'(evt.out_valid), 1);
    chk("p1_id_t2",      int'(evt.out_id), 2);
    chk("p1_pending_t2", int'(pend), 0);
    step(1);
    chk("p1_valid_after_hs", int'(evt.out_valid), 0);
    chk("p1_busy_gap1",      int'(busy), 1);
    step(1);
    chk("p1_busy_gap2",      int'(busy), 1);
    step(1);
    chk("p1_idle_again",     int'(busy), 0);
    req = '0;

    // Round robin: 0,1,3 together, then 0 and 3 with pointer wrapped to 0
    do_reset();
    evt.out_ready = 1'b1;
    req = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    step(1);
    wait_drain("rr_round1_drain", 40);
    req = '0;
    step(1);
    req = 4'b1001;
    exp_q.push_back(0); exp_q.push_back(3);
    step(1);
    wait_drain("rr_round2_drain", 40);
    req = '0;

    // Overflow on line 1 while stalled on line 0
    do_reset();
    evt.out_ready = 1'b0;
    req = 4'b0011;
    exp_q.push_back(0); exp_q.push_back(1);
    step(1);
    chk("ovf_pending_both", int'(pend), 4'b0011);
    step(1);
    chk("ovf_valid0", int'(evt.out_valid), 1);
    chk("ovf_id0",    int'(evt.out_id), 0);
    chk("ovf_pending1", int'(pend), 4'b0010);
    req[1] = 1'b0; step(1);
    req[1] = 1'b1; step(1);
    chk("ovf_set", int'(ovf), 4'b0010);
    chk("ovf_pending_kept", int'(pend), 4'b0010);
    req[1] = 1'b0; step(1);
    req[1] = 1'b1; ovf_clr = 4'b0010; step(1);
    chk("ovf_set_wins", int'(ovf), 4'b0010);
    step(1);
    chk("ovf_cleared", int'(ovf), 0);
    ovf_clr = '0;
    evt.out_ready = 1'b1;
    wait_drain("ovf_drain", 40);
    req = '0;

    // Back-pressure: valid/id held for 6 stalled cycles, accepted on the 7th
    do_reset();
    evt.out_ready = 1'b0;
    req = 4'b1000;
    exp_q.push_back(3);
    step(2);
    for (int k = 1; k <= 7; k++) begin
      chk("stall_valid", int'(evt.out_valid), 1);
      chk("stall_id",    int'(evt.out_id), 3);
      if (k < 7) step(1);
    end
    evt.out_ready = 1'b1;
    step(1);
    chk("stall_accepted", int'(evt.out_valid), 0);
    chk("stall_busy_gap", int'(busy), 1);
    req = '0;
    wait_drain("stall_drain", 40);

    // Asynchronous reset mid-ISSUE with pending and overflow set
    do_reset();
    evt.out_ready = 1'b0;
    req = 4'b0011;
    step(2);
    req[1] = 1'b0; step(1);
    req[1] = 1'b1; step(1);
    chk("arst_pre_valid", int'(evt.out_valid), 1);
    chk("arst_pre_ovf",   int'(ovf), 4'b0010);
    req = 4'b0001;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",    int'(evt.out_valid), 0);
    chk("arst_pending",  int'(pend), 0);
    chk("arst_overflow", int'(ovf), 0);
    chk("arst_busy",     int'(busy), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(0);
    evt.out_ready = 1'b1;
    step(20);
    chk("arst_one_event", exp_q.size(), 0);
    wait_drain("arst_drain", 40);
    req = '0;

    // GAP_CYCLES=0 build: staggered continuous rises, issue every 2 cycles
    do_reset();
    evt0.out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        nx[i] = (c >= 2 * i) && (((c - 2 * i) % 8) < 4);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (nx[i] && !req0[i]) exp0_q.push_back(i);
      end
      req0 = nx;
      step(1);
    end
    req0 = '0;
    wait_drain0("gap0_drain", 40);
    chk("gap0_no_overflow", int'(ovf0), 0);

    chk("sb_empty",  exp_q.size(), 0);
    chk("sb0_empty", exp0_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
